ahb_uart_rx: RTL and testbench

AHB-Lite slave UART receiver: samples the asynchronous `UART_RX` line, assembles 8N1 frames into bytes, buffers them in a small FIFO and exposes DATA/STATUS registers to the MIPS core. It is the receive counterpart of `ahb_uart_tx` and occupies the next free slave port of the AHB-Lite matrix: its own `HSEL`, `HRDATA`/`HRESP` into the response mux, and its `HREADY` ANDed into the matrix `HREADY`.

---
 rtl/ahb_uart_rx_if.sv | 21 ++
 rtl/ahb_uart_rx.sv | 209 ++++++++++++++++++++
 tb/tb_ahb_uart_rx.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_uart_rx_if.sv
// AHB-Lite slave-port signal bundle for ahb_uart_rx; master drives address/data phase, slave responds.
interface ahb_uart_rx_if;
    logic [31:0] HADDR;
    logic        HSEL;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    modport master (
        output HADDR, HSEL, HTRANS, HWRITE, HWDATA,
        input  HRDATA, HREADY, HRESP
    );

    modport slave (
        input  HADDR, HSEL, HTRANS, HWRITE, HWDATA,
        output HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/ahb_uart_rx.sv
// AHB-Lite UART receiver: 8N1 (8E1 with UART_RX_PARITY_EN) deserializer, byte FIFO, DATA/STATUS registers.
// Define UART_RX_PARITY_EN to enable the even-parity bit and the par_err status flag.
module ahb_uart_rx #(
    parameter int unsigned CLKS_PER_BIT    = 434,
    parameter int unsigned FIFO_DEPTH_LOG2 = 3
) (
    input  logic         HCLK,
    input  logic         HRESETn,
    ahb_uart_rx_if.slave bus,
    input  logic         UART_RX
);
    localparam int unsigned CNT_W   = $clog2(CLKS_PER_BIT);
    localparam int unsigned DEPTH   = 1 << FIFO_DEPTH_LOG2;
    localparam int unsigned PTR_W   = FIFO_DEPTH_LOG2;
    localparam int unsigned FCNT_W  = FIFO_DEPTH_LOG2 + 1;
    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY    = 3'd3,
`endif
        S_STOP      = 3'd4,
        S_WAIT_HIGH = 3'd5
    } state_e;

    logic             rx_meta_q, rx_sync_q;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             push_c, frm_set_c;

    logic [7:0]        mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic              ovr_q, ovr_d, frm_q, frm_d;
    logic              wr_stat_q, wr_stat_d;
    logic [31:0]       hrdata_q, hrdata_d;
    logic              xfer_c, rd_data_c, rd_stat_c, pop_c, do_push_c, full_c, empty_c;
    logic              par_bit_c, unused_c;

`ifdef UART_RX_PARITY_EN
    logic par_set_c, par_q, par_d;
    assign par_bit_c = par_q;
    assign unused_c  = ^{bus.HADDR[31:3], bus.HADDR[1:0], bus.HTRANS[0],
                         bus.HWDATA[31:5], bus.HWDATA[1:0]};
`else
    assign par_bit_c = 1'b0;
    assign unused_c  = ^{bus.HADDR[31:3], bus.HADDR[1:0], bus.HTRANS[0],
                         bus.HWDATA[31:4], bus.HWDATA[1:0]};
`endif

    // Receiver state register and line synchronizer
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
        end else begin
            rx_meta_q <= UART_RX;
            rx_sync_q <= rx_meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
        end
    end

    // Frame sequencing; every sample is taken when the bit counter reaches zero
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        push_c    = 1'b0;
        frm_set_c = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_set_c = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (!rx_sync_q) begin
                    state_d = S_START;
                    cnt_d   = HALF_BIT;
                end
            end
            S_START: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (!rx_sync_q) begin
                    state_d = S_DATA;
                    cnt_d   = FULL_BIT;
                    bit_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DATA: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    cnt_d   = FULL_BIT;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    par_set_c = ^{shift_q, rx_sync_q};
                    cnt_d     = FULL_BIT;
                    state_d   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (rx_sync_q) begin
                    push_c  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    frm_set_c = 1'b1;
                    state_d   = S_WAIT_HIGH;
                end
            end
            S_WAIT_HIGH: begin
                if (rx_sync_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Bus decode, FIFO bookkeeping and sticky flags (a set beats a same-cycle clear)
    always_comb begin
        xfer_c    = bus.HSEL & bus.HTRANS[1];
        rd_data_c = xfer_c & ~bus.HWRITE & ~bus.HADDR[2];
        rd_stat_c = xfer_c & ~bus.HWRITE &  bus.HADDR[2];
        wr_stat_d = xfer_c &  bus.HWRITE &  bus.HADDR[2];
        full_c    = (fcnt_q == FCNT_W'(DEPTH));
        empty_c   = (fcnt_q == '0);
        pop_c     = rd_data_c & ~empty_c;
        do_push_c = push_c & (~full_c | pop_c);

        fcnt_d = fcnt_q;
        if (do_push_c && !pop_c) fcnt_d = fcnt_q + FCNT_W'(1);
        else if (!do_push_c && pop_c) fcnt_d = fcnt_q - FCNT_W'(1);

        ovr_d = (push_c & full_c & ~pop_c) | (ovr_q & ~(wr_stat_q & bus.HWDATA[2]));
        frm_d = frm_set_c | (frm_q & ~(wr_stat_q & bus.HWDATA[3]));
`ifdef UART_RX_PARITY_EN
        par_d = par_set_c | (par_q & ~(wr_stat_q & bus.HWDATA[4]));
`endif

        hrdata_d = '0;
        if (pop_c) hrdata_d = {24'b0, mem_q[rd_ptr_q]};
        else if (rd_stat_c) hrdata_d = {27'b0, par_bit_c, frm_q, ovr_q, full_c, ~empty_c};
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            fcnt_q    <= '0;
            ovr_q     <= 1'b0;
            frm_q     <= 1'b0;
            wr_stat_q <= 1'b0;
            hrdata_q  <= '0;
`ifdef UART_RX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            if (do_push_c) begin
                mem_q[wr_ptr_q] <= shift_q;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            fcnt_q    <= fcnt_d;
            ovr_q     <= ovr_d;
            frm_q     <= frm_d;
            wr_stat_q <= wr_stat_d;
            hrdata_q  <= hrdata_d;
`ifdef UART_RX_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    assign bus.HRDATA = hrdata_q;
    assign bus.HREADY = 1'b1;
    assign bus.HRESP  = 1'b0;
endmodule

// File: tb/tb_ahb_uart_rx.sv
// Self-checking bench for ahb_uart_rx: directed and random frames against a queue-based receiver model.
module tb_ahb_uart_rx;
    localparam int unsigned CPB   = 16;
    localparam int unsigned DEPTH = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic rx;

    ahb_uart_rx_if bus ();

    ahb_uart_rx #(
        .CLKS_PER_BIT   (CPB),
        .FIFO_DEPTH_LOG2(3)
    ) dut (
        .HCLK   (clk),
        .HRESETn(rst_n),
        .bus    (bus),
        .UART_RX(rx)
    );

    always #5 clk = ~clk;

    byte unsigned q[$];
    bit m_ovr, m_frm, m_par;
    int checks = 0;
    int errors = 0;

    initial begin
        repeat (60000) @(posedge clk);
        errors++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_status();
        return {27'b0, m_par, m_frm, m_ovr, q.size() == DEPTH, q.size() != 0};
    endfunction

    // Receiver behaviour at the level of whole frames
    task automatic model_frame(input logic [7:0] d, input logic stop, input logic par);
`ifdef UART_RX_PARITY_EN
        if ((^d) ^ par) m_par = 1'b1;
`endif
        if (!stop) m_frm = 1'b1;
        else if (q.size() == DEPTH) m_ovr = 1'b1;
        else q.push_back(d);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par, input int extra_low);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (CPB) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rx = par;
        repeat (CPB) @(negedge clk);
`endif
        rx = stop;
        repeat (CPB + extra_low) @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        model_frame(d, stop, par);
    endtask

    task automatic ahb_read(input logic [31:0] addr, output logic [31:0] d);
        bus.HSEL   = 1'b1;
        bus.HTRANS = 2'b10;
        bus.HADDR  = addr;
        bus.HWRITE = 1'b0;
        @(negedge clk);
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'b00;
        d = bus.HRDATA;
        check("hready", {31'b0, bus.HREADY}, 32'h1);
        check("hresp", {31'b0, bus.HRESP}, 32'h0);
        @(negedge clk);
    endtask

    task automatic read_status_chk(input string tag);
        logic [31:0] d, e;
        e = exp_status();
        ahb_read(32'h4, d);
        check(tag, d, e);
    endtask

    task automatic read_data_chk(input string tag);
        logic [31:0] d, e;
        e = (q.size() != 0) ? {24'b0, q[0]} : 32'h0;
        if (q.size() != 0) void'(q.pop_front());
        ahb_read(32'h0, d);
        check(tag, d, e);
    endtask

    task automatic write_status(input logic [31:0] v);
        bus.HSEL   = 1'b1;
        bus.HTRANS = 2'b10;
        bus.HADDR  = 32'h4;
        bus.HWRITE = 1'b1;
        @(negedge clk);
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'b00;
        bus.HWRITE = 1'b0;
        bus.HWDATA = v;
        @(negedge clk);
        bus.HWDATA = '0;
        if (v[2]) m_ovr = 1'b0;
        if (v[3]) m_frm = 1'b0;
`ifdef UART_RX_PARITY_EN
        if (v[4]) m_par = 1'b0;
`endif
    endtask

    initial begin
        logic [31:0] d1, d2, e1, e2;
        rst_n      = 1'b0;
        rx         = 1'b1;
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'b00;
        bus.HADDR  = '0;
        bus.HWRITE = 1'b0;
        bus.HWDATA = '0;
        repeat (3) @(negedge clk);
        check("rst_hrdata", bus.HRDATA, 32'h0);
        check("rst_hready", {31'b0, bus.HREADY}, 32'h1);
        check("rst_hresp", {31'b0, bus.HRESP}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        read_status_chk("rst_status");
        read_data_chk("rst_data");

        // Single byte
        send_frame(8'hA5, 1'b1, 1'b0, 0);
        check("a5_model_status", exp_status(), 32'h1);
        read_status_chk("a5_status");
        read_data_chk("a5_data");
        read_status_chk("a5_status_after");

        // Fill past capacity
        for (int i = 0; i < 9; i++) send_frame(8'(i), 1'b1, 1'b0, 0);
        read_status_chk("full_ovr_status");
        for (int i = 0; i < 9; i++) read_data_chk($sformatf("drain_%0d", i));
        write_status(32'h4);
        read_status_chk("ovr_cleared");

        // Framing error, long low line, recovery
        send_frame(8'h3C, 1'b0, 1'b0, 40);
        read_status_chk("frm_status");
        read_data_chk("frm_no_byte");
        send_frame(8'h55, 1'b1, 1'b0, 0);
        read_status_chk("frm_recover_status");
        read_data_chk("frm_recover_data");
        write_status(32'h8);
        read_status_chk("frm_cleared");

        // Short glitch on idle line
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (12) @(negedge clk);
        read_status_chk("glitch_status");
        send_frame(8'h96, 1'b1, 1'b0, 0);
        read_data_chk("after_glitch_data");

        // Back-to-back DATA reads
        send_frame(8'h11, 1'b1, 1'b0, 0);
        send_frame(8'h22, 1'b1, 1'b0, 0);
        e1 = {24'b0, q[0]};
        e2 = {24'b0, q[1]};
        void'(q.pop_front());
        void'(q.pop_front());
        bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HADDR = 32'h0; bus.HWRITE = 1'b0;
        @(negedge clk);
        d1 = bus.HRDATA;
        @(negedge clk);
        bus.HSEL = 1'b0; bus.HTRANS = 2'b00;
        d2 = bus.HRDATA;
        @(negedge clk);
        check("b2b_first", d1, e1);
        check("b2b_second", d2, e2);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h01, 1'b1, 1'b0, 0);
        read_status_chk("par_err_set");
        send_frame(8'h03, 1'b1, 1'b0, 0);
        read_status_chk("par_no_new_flag");
        read_data_chk("par_byte0");
        read_data_chk("par_byte1");
        write_status(32'h10);
        read_status_chk("par_cleared");
`endif

        // Random frames, reads and clears
        for (int it = 0; it < 20; it++) begin
            logic [7:0] d;
            logic st, pb;
            d  = 8'($urandom);
            st = ($urandom_range(0, 7) != 0);
            pb = (^d) ^ ($urandom_range(0, 5) == 0);
            send_frame(d, st, pb, 0);
            if ($urandom_range(0, 1) == 1) read_status_chk($sformatf("rnd_status_%0d", it));
            if ($urandom_range(0, 2) == 0) read_data_chk($sformatf("rnd_data_%0d", it));
            if ($urandom_range(0, 4) == 0) write_status(32'($urandom_range(0, 31)));
        end
        while (q.size() != 0) read_data_chk("rnd_drain");
        read_status_chk("rnd_final_status");

        // Reset in the middle of a frame with a byte buffered
        write_status(32'h1C);
        send_frame(8'h77, 1'b1, 1'b0, 0);
        rx = 1'b0;
        repeat (40) @(negedge clk);
        bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HADDR = 32'h4; bus.HWRITE = 1'b0;
        @(negedge clk);
        bus.HSEL = 1'b0; bus.HTRANS = 2'b00;
        check("pre_rst_status", bus.HRDATA, exp_status());
        rst_n = 1'b0;
        #1;
        check("midrst_hrdata", bus.HRDATA, 32'h0);
        rx = 1'b1;
        q.delete();
        m_ovr = 1'b0; m_frm = 1'b0; m_par = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        read_status_chk("postrst_status");
        read_data_chk("postrst_data");
        send_frame(8'h5A, 1'b1, 1'b0, 0);
        read_data_chk("postrst_recover");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
